// File: rtl/btc_pkg.sv
// +----------------------------------------------------------------------------+
// | btc_pkg                                                                    |
// | Shared types, SHA-256 constants and header/target helpers for the scanner. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package btc_pkg;

    localparam int WORD         = 32;
    localparam int HDR_WORDS    = 20;
    localparam int DIGEST_WORDS = 8;
    localparam int NBITS_IDX    = 18;
    localparam int NONCE_IDX    = 19;

    typedef enum logic [2:0] {IDLE, LOAD, HASH, CHECK, DONE} state_t;
    typedef enum logic [1:0] {SHA_IDLE, SHA_ROUND, SHA_FIN} sha_phase_t;

    localparam logic [31:0] SHA_IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] SHA_K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] byteswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Compact nBits -> 256-bit target; a set sign bit means a negative (unreachable) target.
    function automatic logic [255:0] nbits_to_target(input logic [31:0] nbits);
        logic [255:0] mant;
        int unsigned  expo;
        mant = {232'd0, nbits[23:0]};
        expo = {24'd0, nbits[31:24]};
        if (nbits[23])
            return '0;
        else if (expo < 3)
            return mant >> (8 * (3 - expo));
        else if (expo <= 34)
            return mant << (8 * (expo - 3));
        else
            return '1;
    endfunction

    // Full 32-byte reversal of the digest equals a byteswap of every word in place.
    function automatic logic [255:0] digest_to_le256(input logic [255:0] d);
        logic [255:0] r;
        for (int k = 0; k < DIGEST_WORDS; k++)
            r[32*k +: 32] = byteswap32(d[32*k +: 32]);
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitcoin_nonce_scan_sha256d_core.sv
// +----------------------------------------------------------------------------+
// | sha256d_core                                                               |
// | Iterative double SHA-256 of an 80-byte header, one round per clock.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module sha256d_core
    import btc_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [639:0] msg,
    output logic         valid,
    output logic [255:0] digest
);

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    sha_phase_t   r_phase;
    logic [1:0]   r_blk;
    logic [5:0]   r_rnd;
    logic [127:0] r_tail;
    logic [31:0]  r_hs  [8];
    logic [31:0]  r_wk  [8];
    logic [31:0]  r_win [16];

    logic [31:0]  w_hsum [8];
    logic [31:0]  w_nwk  [8];
    logic [31:0]  w_blk1 [16];
    logic [31:0]  w_blk2 [16];
    logic [31:0]  w_t1, w_t2, w_sched;

    always_comb begin
        w_t1 = r_wk[7] + (rotr(r_wk[4], 6) ^ rotr(r_wk[4], 11) ^ rotr(r_wk[4], 25))
             + ((r_wk[4] & r_wk[5]) ^ (~r_wk[4] & r_wk[6])) + SHA_K[r_rnd] + r_win[0];
        w_t2 = (rotr(r_wk[0], 2) ^ rotr(r_wk[0], 13) ^ rotr(r_wk[0], 22))
             + ((r_wk[0] & r_wk[1]) ^ (r_wk[0] & r_wk[2]) ^ (r_wk[1] & r_wk[2]));
        w_nwk[0] = w_t1 + w_t2;
        w_nwk[1] = r_wk[0];
        w_nwk[2] = r_wk[1];
        w_nwk[3] = r_wk[2];
        w_nwk[4] = r_wk[3] + w_t1;
        w_nwk[5] = r_wk[4];
        w_nwk[6] = r_wk[5];
        w_nwk[7] = r_wk[6];
        // Window holds W[t..t+15]; this produces W[t+16].
        w_sched = (rotr(r_win[14], 17) ^ rotr(r_win[14], 19) ^ (r_win[14] >> 10)) + r_win[9]
                + (rotr(r_win[1], 7) ^ rotr(r_win[1], 18) ^ (r_win[1] >> 3)) + r_win[0];
        for (int k = 0; k < 8; k++)
            w_hsum[k] = r_hs[k] + r_wk[k];
        for (int k = 0; k < 16; k++) begin
            w_blk1[k] = '0;
            w_blk2[k] = '0;
        end
        for (int k = 0; k < 4; k++)
            w_blk1[k] = r_tail[32*k +: 32];
        w_blk1[4]  = 32'h8000_0000;
        w_blk1[15] = 32'd640;
        for (int k = 0; k < 8; k++)
            w_blk2[k] = w_hsum[k];
        w_blk2[8]  = 32'h8000_0000;
        w_blk2[15] = 32'd256;
    end

    always_ff @(posedge clk) begin
        valid <= 1'b0;
        if (reset) begin
            r_phase <= SHA_IDLE;
            r_blk   <= '0;
            r_rnd   <= '0;
            r_tail  <= '0;
            digest  <= '0;
            for (int k = 0; k < 8; k++) begin
                r_hs[k] <= '0;
                r_wk[k] <= '0;
            end
            for (int k = 0; k < 16; k++)
                r_win[k] <= '0;
        end else begin
            case (r_phase)
                SHA_IDLE: begin
                    if (start) begin
                        r_tail <= msg[639:512];
                        r_blk  <= 2'd0;
                        r_rnd  <= 6'd0;
                        for (int k = 0; k < 8; k++) begin
                            r_hs[k] <= SHA_IV[k];
                            r_wk[k] <= SHA_IV[k];
                        end
                        for (int k = 0; k < 16; k++)
                            r_win[k] <= msg[32*k +: 32];
                        r_phase <= SHA_ROUND;
                    end
                end
                SHA_ROUND: begin
                    for (int k = 0; k < 8; k++)
                        r_wk[k] <= w_nwk[k];
                    for (int k = 0; k < 15; k++)
                        r_win[k] <= r_win[k+1];
                    r_win[15] <= w_sched;
                    r_rnd     <= r_rnd + 6'd1;
                    if (r_rnd == 6'd63)
                        r_phase <= SHA_FIN;
                end
                SHA_FIN: begin
                    r_rnd <= 6'd0;
                    if (r_blk == 2'd2) begin
                        for (int k = 0; k < 8; k++)
                            digest[32*k +: 32] <= w_hsum[k];
                        valid   <= 1'b1;
                        r_phase <= SHA_IDLE;
                    end else if (r_blk == 2'd0) begin
                        for (int k = 0; k < 8; k++) begin
                            r_hs[k] <= w_hsum[k];
                            r_wk[k] <= w_hsum[k];
                        end
                        for (int k = 0; k < 16; k++)
                            r_win[k] <= w_blk1[k];
                        r_blk   <= 2'd1;
                        r_phase <= SHA_ROUND;
                    end else begin
                        // Second pass restarts from IV over the first-pass digest.
                        for (int k = 0; k < 8; k++) begin
                            r_hs[k] <= SHA_IV[k];
                            r_wk[k] <= SHA_IV[k];
                        end
                        for (int k = 0; k < 16; k++)
                            r_win[k] <= w_blk2[k];
                        r_blk   <= 2'd2;
                        r_phase <= SHA_ROUND;
                    end
                end
                default: r_phase <= SHA_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/bitcoin_nonce_scan.sv
// +----------------------------------------------------------------------------+
// | bitcoin_nonce_scan                                                         |
// | Nonce scanner: double-SHA-256 per candidate, stop on hit/limit/wrap.       |
// | Optional BTC_HASH_COUNTER_EN adds the hash_count output.                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bitcoin_nonce_scan
    import btc_pkg::*;
#(
    parameter logic [31:0] MAX_ITER = 32'd0,
    parameter int          W        = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic [HDR_WORDS*W-1:0]        in_fifo,
    output logic [DIGEST_WORDS*W-1:0]     out_fifo,
    output logic                          done,
    output logic                          found,
    output logic [W-1:0]                  nonce_out
`ifdef BTC_HASH_COUNTER_EN
    ,
    output logic [31:0]                   hash_count
`endif
);

    state_t         r_state;
    logic [607:0]   r_hdr;
    logic [255:0]   r_target;
    logic [31:0]    r_nonce;
    logic [31:0]    r_start_nonce;
    logic [31:0]    r_iter;
    logic           r_issued;
    logic           r_inflight;

    logic           w_sha_start;
    logic           w_sha_valid;
    logic [255:0]   w_sha_digest;
    logic [639:0]   w_msg;
    logic           w_hit;

    assign w_msg       = {byteswap32(r_nonce), r_hdr};
    assign w_hit       = (digest_to_le256(out_fifo) <= r_target);
    // Held off while an aborted job's hash is still draining out of the core.
    assign w_sha_start = (r_state == HASH) && !r_issued && !r_inflight;

    sha256d_core u_sha (
        .clk    (clk),
        .reset  (reset),
        .start  (w_sha_start),
        .msg    (w_msg),
        .valid  (w_sha_valid),
        .digest (w_sha_digest)
    );

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (reset) begin
            r_state       <= IDLE;
            r_hdr         <= '0;
            r_target      <= '0;
            r_nonce       <= '0;
            r_start_nonce <= '0;
            r_iter        <= '0;
            r_issued      <= 1'b0;
            r_inflight    <= 1'b0;
            out_fifo      <= '0;
            found         <= 1'b0;
            nonce_out     <= '0;
`ifdef BTC_HASH_COUNTER_EN
            hash_count    <= '0;
`endif
        end else begin
            if (w_sha_start)
                r_inflight <= 1'b1;
            else if (w_sha_valid)
                r_inflight <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (en)
                        r_state <= LOAD;
                end
                LOAD: begin
                    if (!en) begin
                        r_state <= IDLE;
                    end else begin
                        r_hdr         <= in_fifo[607:0];
                        r_target      <= nbits_to_target(byteswap32(in_fifo[32*NBITS_IDX +: 32]));
                        r_nonce       <= byteswap32(in_fifo[32*NONCE_IDX +: 32]);
                        r_start_nonce <= byteswap32(in_fifo[32*NONCE_IDX +: 32]);
                        r_iter        <= '0;
                        r_issued      <= 1'b0;
                        found         <= 1'b0;
`ifdef BTC_HASH_COUNTER_EN
                        hash_count    <= '0;
`endif
                        r_state       <= HASH;
                    end
                end
                HASH: begin
                    if (!en) begin
                        r_state <= IDLE;
                    end else begin
                        if (w_sha_start)
                            r_issued <= 1'b1;
                        if (w_sha_valid && r_issued) begin
                            out_fifo  <= w_sha_digest;
                            nonce_out <= r_nonce;
                            r_iter    <= r_iter + 32'd1;
`ifdef BTC_HASH_COUNTER_EN
                            if (hash_count != 32'hFFFF_FFFF)
                                hash_count <= hash_count + 32'd1;
`endif
                            r_state   <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (!en) begin
                        r_state <= IDLE;
                    end else if (w_hit) begin
                        found   <= 1'b1;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else if ((MAX_ITER != 32'd0) && (r_iter == MAX_ITER)) begin
                        found   <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else if ((r_nonce + 32'd1) == r_start_nonce) begin
                        found   <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_nonce  <= r_nonce + 32'd1;
                        r_issued <= 1'b0;
                        r_state  <= HASH;
                    end
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bitcoin_nonce_scan.sv
// +----------------------------------------------------------------------------+
// | tb_bitcoin_nonce_scan                                                      |
// | Scoreboard bench for the nonce scanner using genesis-block vectors.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bitcoin_nonce_scan;

    typedef struct packed {
        logic         found;
        logic [31:0]  nonce;
        logic         chk_dig;
        logic [255:0] dig;
    } exp_t;

    localparam int BUDGET = 3000;
    localparam logic [255:0] GEN_DIG = {32'h00000000, 32'h68d61900, 32'he15a089c, 32'h931e8365,
                                        32'hae63f74f, 32'hc1a6a246, 32'hb6f1b372, 32'h6fe28c0a};

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         en = 1'b0;
    logic [639:0] in_fifo = '0;
    logic [255:0] out_fifo;
    logic         done;
    logic         found;
    logic [31:0]  nonce_out;
`ifdef BTC_HASH_COUNTER_EN
    logic [31:0]  hash_count;
`endif

    int   total = 0;
    int   bad = 0;
    exp_t sb [$];

    always #5 clk = ~clk;

    bitcoin_nonce_scan #(.MAX_ITER(32'd4), .W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .in_fifo   (in_fifo),
        .out_fifo  (out_fifo),
        .done      (done),
        .found     (found),
        .nonce_out (nonce_out)
`ifdef BTC_HASH_COUNTER_EN
        ,
        .hash_count(hash_count)
`endif
    );

    function automatic logic [639:0] mk_hdr(input logic [31:0] nbits_w, input logic [31:0] nonce_w);
        logic [31:0] w [20];
        logic [639:0] h;
        for (int i = 0; i < 20; i++) w[i] = '0;
        w[0]  = 32'h01000000;
        w[9]  = 32'h3ba3edfd; w[10] = 32'h7a7b12b2; w[11] = 32'h7ac72c3e; w[12] = 32'h67768f61;
        w[13] = 32'h7fc81bc3; w[14] = 32'h888a5132; w[15] = 32'h3a9fb8aa; w[16] = 32'h4b1e5e4a;
        w[17] = 32'h29ab5f49; w[18] = nbits_w;      w[19] = nonce_w;
        for (int i = 0; i < 20; i++) h[32*i +: 32] = w[i];
        return h;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 want no done");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("found", {255'd0, found}, {255'd0, e.found});
                check("nonce_out", {224'd0, nonce_out}, {224'd0, e.nonce});
                if (e.chk_dig)
                    check("digest", out_fifo, e.dig);
            end
        end
    end

    task automatic start_job(input logic [639:0] h, input exp_t e);
        sb.push_back(e);
        in_fifo = h;
        en = 1'b1;
    endtask

    task automatic wait_done();
        int cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done !== 1'b1 && cyc < BUDGET);
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done after %0d cycles want done", cyc);
            sb.delete();
        end
        en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        repeat (3) @(negedge clk);
        check("rst_done", {255'd0, done}, 256'd0);
        check("rst_found", {255'd0, found}, 256'd0);
        check("rst_nonce", {224'd0, nonce_out}, 256'd0);
        check("rst_digest", out_fifo, 256'd0);
        reset = 1'b0;
        @(negedge clk);

        // Genesis header as-is: hit on the first hash.
        e = '{1'b1, 32'h7C2BAC1D, 1'b1, GEN_DIG};
        start_job(mk_hdr(32'hFFFF001D, 32'h1DAC2B7C), e); wait_done();

        // Two misses then the genesis nonce.
        e = '{1'b1, 32'h7C2BAC1D, 1'b1, GEN_DIG};
        start_job(mk_hdr(32'hFFFF001D, 32'h1BAC2B7C), e);
`ifdef BTC_HASH_COUNTER_EN
        wait_done();
        check("hash_count_3", {224'd0, hash_count}, 256'd3);
        e = '{1'b1, 32'h7C2BAC1D, 1'b1, GEN_DIG};
        start_job(mk_hdr(32'hFFFF001D, 32'h1DAC2B7C), e);
        @(negedge clk); @(negedge clk);
        check("hash_count_clr", {224'd0, hash_count}, 256'd0);
`endif
        wait_done();

        // Nonce 0: iteration limit of 4 reached first.
        e = '{1'b0, 32'd3, 1'b0, 256'd0};
        start_job(mk_hdr(32'hFFFF001D, 32'h00000000), e); wait_done();

        // Exponent 0x23: target all ones, any digest hits.
        e = '{1'b1, 32'h7C2BAC1D, 1'b0, 256'd0};
        start_job(mk_hdr(32'hFFFF0023, 32'h1DAC2B7C), e); wait_done();

        // Mantissa sign bit set: target zero, runs to the limit from nonce 5.
        e = '{1'b0, 32'd8, 1'b0, 256'd0};
        start_job(mk_hdr(32'hFFFF801D, 32'h05000000), e); wait_done();

        // Abort mid-HASH: no done expected, then a clean job.
        in_fifo = mk_hdr(32'hFFFF001D, 32'h1BAC2B7C);
        en = 1'b1;
        repeat (20) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        e = '{1'b1, 32'h7C2BAC1D, 1'b1, GEN_DIG};
        start_job(mk_hdr(32'hFFFF001D, 32'h1DAC2B7C), e); wait_done();

        // Reset mid-job clears every output on the next cycle.
        in_fifo = mk_hdr(32'hFFFF001D, 32'h1BAC2B7C);
        en = 1'b1;
        repeat (30) @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        @(negedge clk);
        check("mid_rst_done", {255'd0, done}, 256'd0);
        check("mid_rst_found", {255'd0, found}, 256'd0);
        check("mid_rst_nonce", {224'd0, nonce_out}, 256'd0);
        check("mid_rst_digest", out_fifo, 256'd0);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        e = '{1'b1, 32'h7C2BAC1D, 1'b1, GEN_DIG};
        start_job(mk_hdr(32'hFFFF001D, 32'h1DAC2B7C), e); wait_done();

        check("sb_empty", 256'(sb.size()), 256'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
